// File: rtl/ddr4_lane_dly_ctrl.sv
// Sequences LOAD / STEP / SEARCH commands onto one DDR4 lane delay line pair (RX/TX DQS).
// Tracks both tap counters locally so the host never has to read the lane back.
module ddr4_lane_dly_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [7:0]  TAP_PRESET    = 8'd1
) (
    input  logic       FAB_CLK,
    input  logic       RESET_N,
    input  logic       START,
    input  logic [1:0] CMD,
    input  logic       LINE_SEL,
    input  logic       STEP_DIR,
    input  logic [7:0] STEP_CNT,
    input  logic       RX_BURST_DETECT,
    input  logic       RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
    output logic       DELAY_LINE_SEL,
    output logic       DELAY_LINE_DIRECTION,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR,
    output logic       EDGE_FOUND,
    output logic [7:0] TAP_COUNT,
    output logic [7:0] EDGE_TAP
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, SETTLE, CHECK, FIN} state_t;

    localparam logic [1:0] CMD_LOAD    = 2'b00;
    localparam logic [1:0] CMD_SEARCH  = 2'b10;
    localparam logic [1:0] CMD_NOP     = 2'b11;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] cmd_q, cmd_d;
    logic       sel_q, sel_d;
    logic       dir_q, dir_d;
    logic [7:0] rem_q, rem_d;
    logic [3:0] settle_q, settle_d;
    logic [7:0] rx_tap_q, rx_tap_d;
    logic [7:0] tx_tap_q, tx_tap_d;
    logic [7:0] edge_tap_q, edge_tap_d;
    logic       move_q, move_d;
    logic       load_q, load_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       edge_found_q, edge_found_d;

    logic [7:0] cur_tap;
    logic       move_blocked;
    logic       oor;

    assign cur_tap      = sel_q ? tx_tap_q : rx_tap_q;
    assign move_blocked = dir_q ? (cur_tap == 8'hFF) : (cur_tap == 8'h00);
    assign oor          = sel_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        sel_d        = sel_q;
        dir_d        = dir_q;
        rem_d        = rem_q;
        settle_d     = settle_q;
        rx_tap_d     = rx_tap_q;
        tx_tap_d     = tx_tap_q;
        edge_tap_d   = edge_tap_q;
        err_d        = err_q;
        edge_found_d = edge_found_q;
        move_d       = 1'b0;
        load_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (START) begin
                    err_d        = 1'b0;
                    edge_found_d = 1'b0;
                    if (CMD == CMD_NOP) begin
                        state_d = FIN;
                    end else begin
                        state_d = SETUP;
                        cmd_d   = CMD;
                        sel_d   = LINE_SEL;
                        dir_d   = (CMD == CMD_SEARCH) ? 1'b1 : STEP_DIR;
                        rem_d   = STEP_CNT;
                    end
                end
            end
            SETUP: begin
                if (cmd_q == CMD_LOAD) begin
                    state_d = PULSE;
                end else if (rem_q == 8'd0) begin
                    state_d = FIN;
                end else if (move_blocked) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                state_d  = SETTLE;
                settle_d = SETTLE_LAST;
            end
            SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = (cmd_q == CMD_LOAD) ? FIN : CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            CHECK: begin
                // Range error outranks a burst seen in the same sample.
                if (oor) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else if ((cmd_q == CMD_SEARCH) && RX_BURST_DETECT) begin
                    edge_found_d = 1'b1;
                    edge_tap_d   = cur_tap;
                    state_d      = FIN;
                end else if (rem_q == 8'd0) begin
                    state_d = FIN;
                end else if (move_blocked) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    state_d = PULSE;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The tap counter follows the pulse in the same cycle it appears on the lane.
        if (state_d == PULSE) begin
            if (cmd_q == CMD_LOAD) begin
                load_d = 1'b1;
                if (sel_q) tx_tap_d = TAP_PRESET;
                else       rx_tap_d = TAP_PRESET;
            end else begin
                move_d = 1'b1;
                rem_d  = rem_q - 8'd1;
                if (sel_q) tx_tap_d = dir_q ? tx_tap_q + 8'd1 : tx_tap_q - 8'd1;
                else       rx_tap_d = dir_q ? rx_tap_q + 8'd1 : rx_tap_q - 8'd1;
            end
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == FIN);
    end

    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            cmd_q        <= CMD_LOAD;
            sel_q        <= 1'b0;
            dir_q        <= 1'b0;
            rem_q        <= 8'd0;
            settle_q     <= 4'd0;
            rx_tap_q     <= TAP_PRESET;
            tx_tap_q     <= TAP_PRESET;
            edge_tap_q   <= 8'd0;
            move_q       <= 1'b0;
            load_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            edge_found_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            sel_q        <= sel_d;
            dir_q        <= dir_d;
            rem_q        <= rem_d;
            settle_q     <= settle_d;
            rx_tap_q     <= rx_tap_d;
            tx_tap_q     <= tx_tap_d;
            edge_tap_q   <= edge_tap_d;
            move_q       <= move_d;
            load_q       <= load_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            edge_found_q <= edge_found_d;
        end
    end

    assign DELAY_LINE_SEL       = sel_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign BUSY                 = busy_q;
    assign DONE                 = done_q;
    assign ERR                  = err_q;
    assign EDGE_FOUND           = edge_found_q;
    assign EDGE_TAP             = edge_tap_q;
    assign TAP_COUNT            = LINE_SEL ? tx_tap_q : rx_tap_q;

endmodule

// File: tb/tb_ddr4_lane_dly_ctrl.sv
// Directed bench for ddr4_lane_dly_ctrl: each command pushes its expected outcome to a
// scoreboard queue, which is popped and compared when the DUT pulses DONE.
module tb_ddr4_lane_dly_ctrl;

    localparam int S = 4;

    logic       FAB_CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic [1:0] CMD = 2'b00;
    logic       LINE_SEL = 1'b0;
    logic       STEP_DIR = 1'b0;
    logic [7:0] STEP_CNT = 8'd0;
    logic       RX_BURST_DETECT = 1'b0;
    logic       RX_OOR = 1'b0;
    logic       TX_OOR = 1'b0;
    logic       DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, DELAY_LINE_MOVE;
    logic       BUSY, DONE, ERR, EDGE_FOUND;
    logic [7:0] TAP_COUNT, EDGE_TAP;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        int         done_off;
        int         moves;
        int         loads;
        logic       err;
        logic       ef;
        logic [7:0] etap;
    } exp_t;

    exp_t sb[$];

    ddr4_lane_dly_ctrl #(
        .SETTLE_CYCLES(S),
        .TAP_PRESET(8'd1)
    ) dut (
        .FAB_CLK(FAB_CLK),
        .RESET_N(RESET_N),
        .START(START),
        .CMD(CMD),
        .LINE_SEL(LINE_SEL),
        .STEP_DIR(STEP_DIR),
        .STEP_CNT(STEP_CNT),
        .RX_BURST_DETECT(RX_BURST_DETECT),
        .RX_DELAY_LINE_OUT_OF_RANGE(RX_OOR),
        .TX_DELAY_LINE_OUT_OF_RANGE(TX_OOR),
        .DELAY_LINE_SEL(DELAY_LINE_SEL),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .BUSY(BUSY),
        .DONE(DONE),
        .ERR(ERR),
        .EDGE_FOUND(EDGE_FOUND),
        .TAP_COUNT(TAP_COUNT),
        .EDGE_TAP(EDGE_TAP)
    );

    always #5 FAB_CLK = ~FAB_CLK;
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_tap(input string tag, input logic line, input int exp);
        LINE_SEL = line;
        #1;
        check(tag, {24'd0, TAP_COUNT}, exp);
    endtask

    function automatic exp_t mk(input int done_off, input int moves, input int loads,
                                input logic err, input logic ef, input logic [7:0] etap);
        exp_t e;
        e.done_off = done_off;
        e.moves    = moves;
        e.loads    = loads;
        e.err      = err;
        e.ef       = ef;
        e.etap     = etap;
        return e;
    endfunction

    // Issues one command, watches pulses cycle by cycle, then pops the scoreboard on DONE.
    task automatic exec(input string tag, input logic [1:0] cmd, input logic sel, input logic dir,
                        input logic [7:0] cnt, input int oor_at, input int burst_at, input bit inject);
        int   t0, moves, loads, dcyc;
        bit   seen;
        logic exp_dir;
        exp_t e;
        exp_dir = (cmd == 2'b10) ? 1'b1 : dir;
        @(negedge FAB_CLK);
        START = 1'b1; CMD = cmd; LINE_SEL = sel; STEP_DIR = dir; STEP_CNT = cnt;
        t0 = cyc; moves = 0; loads = 0; dcyc = -1; seen = 1'b0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge FAB_CLK);
            if (inject && cyc == t0 + 5) begin
                START = 1'b1; CMD = 2'b00; LINE_SEL = ~sel; STEP_DIR = ~dir;
            end else begin
                START = 1'b0; CMD = cmd; LINE_SEL = sel; STEP_DIR = dir;
            end
            if (DELAY_LINE_MOVE) begin
                check({tag, "_move_cyc"}, cyc - t0, 2 + moves * (S + 2));
                check({tag, "_move_sel"}, {31'd0, DELAY_LINE_SEL}, {31'd0, sel});
                check({tag, "_move_dir"}, {31'd0, DELAY_LINE_DIRECTION}, {31'd0, exp_dir});
                moves++;
                if (moves == oor_at) begin
                    if (sel) TX_OOR = 1'b1;
                    else     RX_OOR = 1'b1;
                end
                if (moves == burst_at) RX_BURST_DETECT = 1'b1;
            end
            if (DELAY_LINE_LOAD) begin
                check({tag, "_load_cyc"}, cyc - t0, 2);
                check({tag, "_load_sel"}, {31'd0, DELAY_LINE_SEL}, {31'd0, sel});
                loads++;
            end
            if (DONE) begin
                seen = 1'b1;
                dcyc = cyc - t0;
                check({tag, "_busy_fin"}, {31'd0, BUSY}, 1);
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 1);
        e = sb.pop_front();
        check({tag, "_done_cyc"}, dcyc, e.done_off);
        check({tag, "_moves"}, moves, e.moves);
        check({tag, "_loads"}, loads, e.loads);
        check({tag, "_err"}, {31'd0, ERR}, {31'd0, e.err});
        check({tag, "_edge_found"}, {31'd0, EDGE_FOUND}, {31'd0, e.ef});
        check({tag, "_edge_tap"}, {24'd0, EDGE_TAP}, {24'd0, e.etap});
        RX_BURST_DETECT = 1'b0; RX_OOR = 1'b0; TX_OOR = 1'b0; START = 1'b0;
        @(negedge FAB_CLK);
        check({tag, "_busy_after"}, {31'd0, BUSY}, 0);
        check({tag, "_done_pulse"}, {31'd0, DONE}, 0);
        $display("txn %s: done_off=%0d moves=%0d loads=%0d err=%0b edge_found=%0b edge_tap=%0d",
                 tag, dcyc, moves, loads, ERR, EDGE_FOUND, EDGE_TAP);
    endtask

    initial begin
        int rmoves;
        bit seen;
        // Power-on reset and reset state
        repeat (3) @(negedge FAB_CLK);
        check("rst_busy", {31'd0, BUSY}, 0);
        check("rst_done", {31'd0, DONE}, 0);
        check("rst_err", {31'd0, ERR}, 0);
        check("rst_ef", {31'd0, EDGE_FOUND}, 0);
        check("rst_move", {31'd0, DELAY_LINE_MOVE}, 0);
        check("rst_load", {31'd0, DELAY_LINE_LOAD}, 0);
        check("rst_sel", {31'd0, DELAY_LINE_SEL}, 0);
        check("rst_dir", {31'd0, DELAY_LINE_DIRECTION}, 0);
        check("rst_etap", {24'd0, EDGE_TAP}, 0);
        chk_tap("rst_rx_tap", 1'b0, 1);
        chk_tap("rst_tx_tap", 1'b1, 1);
        @(negedge FAB_CLK);
        RESET_N = 1'b1;
        repeat (2) @(negedge FAB_CLK);

        sb.push_back(mk(3 + S, 0, 1, 1'b0, 1'b0, 8'd0));
        exec("load_rx", 2'b00, 1'b0, 1'b0, 8'd0, 0, 0, 1'b0);
        chk_tap("load_rx_tap", 1'b0, 1);

        // Burst is held high throughout: a STEP must ignore it; a START mid-command is dropped.
        RX_BURST_DETECT = 1'b1;
        sb.push_back(mk(2 + 3 * (S + 2), 3, 0, 1'b0, 1'b0, 8'd0));
        exec("step_tx_up3", 2'b01, 1'b1, 1'b1, 8'd3, 0, 0, 1'b1);
        chk_tap("step_tx_up3_tx", 1'b1, 4);
        chk_tap("step_tx_up3_rx", 1'b0, 1);

        sb.push_back(mk(2 + 5 * (S + 2), 5, 0, 1'b0, 1'b1, 8'd6));
        exec("search_rx", 2'b10, 1'b0, 1'b0, 8'd10, 0, 5, 1'b0);
        chk_tap("search_rx_tap", 1'b0, 6);

        sb.push_back(mk(3 + S, 0, 1, 1'b0, 1'b0, 8'd6));
        exec("reload_rx", 2'b00, 1'b0, 1'b0, 8'd0, 0, 0, 1'b0);
        chk_tap("reload_rx_tap", 1'b0, 1);

        sb.push_back(mk(2 + 1 * (S + 2), 1, 0, 1'b1, 1'b0, 8'd6));
        exec("step_rx_dn_floor", 2'b01, 1'b0, 1'b0, 8'd3, 0, 0, 1'b0);
        chk_tap("step_rx_dn_floor_tap", 1'b0, 0);

        sb.push_back(mk(2, 0, 0, 1'b0, 1'b0, 8'd6));
        exec("step_cnt0", 2'b01, 1'b0, 1'b1, 8'd0, 0, 0, 1'b0);
        chk_tap("step_cnt0_tap", 1'b0, 0);

        sb.push_back(mk(2 + 2 * (S + 2), 2, 0, 1'b1, 1'b0, 8'd6));
        exec("step_rx_oor", 2'b01, 1'b0, 1'b1, 8'd5, 2, 0, 1'b0);
        chk_tap("step_rx_oor_tap", 1'b0, 2);

        sb.push_back(mk(1, 0, 0, 1'b0, 1'b0, 8'd6));
        exec("reserved_nop", 2'b11, 1'b0, 1'b1, 8'd4, 0, 0, 1'b0);

        sb.push_back(mk(2 + 3 * (S + 2), 3, 0, 1'b0, 1'b0, 8'd6));
        exec("search_tx_miss", 2'b10, 1'b1, 1'b0, 8'd3, 0, 0, 1'b0);
        chk_tap("search_tx_miss_tap", 1'b1, 7);

        // Reset asserted during SETTLE of a STEP
        @(negedge FAB_CLK);
        START = 1'b1; CMD = 2'b01; LINE_SEL = 1'b1; STEP_DIR = 1'b1; STEP_CNT = 8'd5;
        @(negedge FAB_CLK);
        START = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE) seen = 1'b1;
        end
        check("midrst_first_move", {31'd0, seen}, 1);
        @(negedge FAB_CLK);
        RESET_N = 1'b0;
        @(negedge FAB_CLK);
        check("midrst_busy", {31'd0, BUSY}, 0);
        check("midrst_move", {31'd0, DELAY_LINE_MOVE}, 0);
        check("midrst_sel", {31'd0, DELAY_LINE_SEL}, 0);
        check("midrst_dir", {31'd0, DELAY_LINE_DIRECTION}, 0);
        check("midrst_etap", {24'd0, EDGE_TAP}, 0);
        chk_tap("midrst_tx_tap", 1'b1, 1);
        chk_tap("midrst_rx_tap", 1'b0, 1);
        RESET_N = 1'b1;
        rmoves = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE || DELAY_LINE_LOAD || DONE) rmoves++;
        end
        check("midrst_no_pulses", rmoves, 0);
        $display("txn midrst: pulses_after_reset=%0d", rmoves);

        sb.push_back(mk(2 + 254 * (S + 2), 254, 0, 1'b1, 1'b0, 8'd0));
        exec("step_tx_ceiling", 2'b01, 1'b1, 1'b1, 8'd255, 0, 0, 1'b0);
        chk_tap("step_tx_ceiling_tap", 1'b1, 255);

        sb.push_back(mk(2, 0, 0, 1'b1, 1'b0, 8'd0));
        exec("step_tx_blocked", 2'b01, 1'b1, 1'b1, 8'd1, 0, 0, 1'b0);
        chk_tap("step_tx_blocked_tap", 1'b1, 255);

        sb.push_back(mk(2 + 2 * (S + 2), 2, 0, 1'b0, 1'b0, 8'd0));
        exec("step_tx_dn2", 2'b01, 1'b1, 1'b0, 8'd2, 0, 0, 1'b0);
        chk_tap("step_tx_dn2_tap", 1'b1, 253);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
